// File: rtl/im2col_row_packer_pkg.sv
// im2col_row_packer_pkg: shared widths, FSM states and the row-length helper.
package im2col_row_packer_pkg;
    localparam int ADDR_SIZE     = 16;
    localparam int KERNEL_SIZE   = 4;
    localparam int CHANNELS_SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic [15:0] row_len(input logic [KERNEL_SIZE-1:0] k,
                                            input logic [CHANNELS_SIZE-1:0] c);
        return 16'(k) * 16'(k) * 16'(c);
    endfunction
endpackage

// File: rtl/im2col_row_packer_addr_fifo.sv
// im2col_row_packer_addr_fifo: synchronous address FIFO with synchronous clear and free-entry count.
module im2col_row_packer_addr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr;

    always_comb begin
        wr    = push && (!full || pop);
        mem_d = mem_q;
        if (wr) mem_d[wp_q] = din;
        wp_d  = wp_q + AW'(wr);
        rp_d  = rp_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rp_q];
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign free  = (AW+1)'(DEPTH) - cnt_q;
endmodule

// File: rtl/im2col_row_packer.sv
// im2col_row_packer: reads tensor SRAM per queued address and packs L=K*K*C elements into rows.
// Optional row counter output o_row_cnt when IM2COL_ROW_CNT_EN is defined.
module im2col_row_packer
    import im2col_row_packer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ROW_MAX    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic [KERNEL_SIZE-1:0]    kernel_size,
    input  logic [CHANNELS_SIZE-1:0]  channels,
    input  logic [ADDR_SIZE-1:0]      i_addr,
    input  logic                      i_addr_valid,
    input  logic                      i_done,
    output logic                      o_addr_ready,
    output logic [ADDR_SIZE-1:0]      o_mem_addr,
    output logic                      o_mem_ren,
    input  logic [DATA_W-1:0]         i_mem_rdata,
    output logic [ROW_MAX*DATA_W-1:0] o_row_data,
    output logic [5:0]                o_row_len,
    output logic                      o_row_valid,
    input  logic                      i_row_ready,
`ifdef IM2COL_ROW_CNT_EN
    output logic [15:0]               o_row_cnt,
`endif
    output logic                      o_all_done,
    output logic                      o_cfg_err
);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_e                    state_q, state_d;
    logic [5:0]                len_q, len_d, issued_q, issued_d, wr_idx_q, wr_idx_d;
    logic                      rd_vld_q, rd_vld_d, row_valid_q, row_valid_d;
    logic                      all_done_q, all_done_d, cfg_err_q, cfg_err_d;
    logic [ROW_MAX*DATA_W-1:0] row_q, row_d;
    logic [15:0]               l_full;
    logic                      push, pop, full, empty, accept;
    logic [ADDR_SIZE-1:0]      head;
    logic [FW-1:0]             free;

    im2col_row_packer_addr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_SIZE)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (!enable),
        .push  (push),
        .pop   (pop),
        .din   (i_addr),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .free  (free)
    );

    always_comb begin
        l_full      = row_len(kernel_size, channels);
        push        = enable && i_addr_valid && state_q != ST_IDLE && state_q != ST_ERR;
        pop         = enable && state_q == ST_FILL && !empty && issued_q < len_q;
        accept      = row_valid_q && i_row_ready;
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q + 6'(pop);
        wr_idx_d    = wr_idx_q + 6'(rd_vld_q);
        rd_vld_d    = pop;
        row_valid_d = row_valid_q;
        all_done_d  = all_done_q;
        cfg_err_d   = cfg_err_q;
        row_d       = row_q;
        for (int i = 0; i < ROW_MAX; i++)
            if (rd_vld_q && wr_idx_q == 6'(i)) row_d[i*DATA_W +: DATA_W] = i_mem_rdata;
        case (state_q)
            ST_IDLE: begin
                len_d     = l_full[5:0];
                cfg_err_d = l_full == '0 || l_full > 16'(ROW_MAX);
                state_d   = cfg_err_d ? ST_ERR : ST_FILL;
            end
            ST_FILL: begin
                if (rd_vld_q && wr_idx_q == len_q - 6'd1) begin
                    row_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (i_done && empty && !rd_vld_q) begin
                    // Unwritten slots are already zero: the buffer is cleared on every accept.
                    row_valid_d = wr_idx_q != '0;
                    all_done_d  = wr_idx_q == '0;
                    state_d     = wr_idx_q != '0 ? ST_HOLD : ST_DONE;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    row_valid_d = 1'b0;
                    issued_d    = '0;
                    wr_idx_d    = '0;
                    row_d       = '0;
                    state_d     = ST_FILL;
                end
            end
            default: ;
        endcase
        if (!enable) begin
            state_d     = ST_IDLE;
            len_d       = '0;
            issued_d    = '0;
            wr_idx_d    = '0;
            rd_vld_d    = 1'b0;
            row_valid_d = 1'b0;
            all_done_d  = 1'b0;
            cfg_err_d   = 1'b0;
            row_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            wr_idx_q    <= '0;
            rd_vld_q    <= 1'b0;
            row_valid_q <= 1'b0;
            all_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            wr_idx_q    <= wr_idx_d;
            rd_vld_q    <= rd_vld_d;
            row_valid_q <= row_valid_d;
            all_done_q  <= all_done_d;
            cfg_err_q   <= cfg_err_d;
            row_q       <= row_d;
        end
    end

`ifdef IM2COL_ROW_CNT_EN
    logic [15:0] row_cnt_q, row_cnt_d;

    always_comb row_cnt_d = !enable ? '0 : (accept && row_cnt_q != 16'hFFFF) ? row_cnt_q + 16'd1 : row_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) row_cnt_q <= '0;
        else       row_cnt_q <= row_cnt_d;
    end

    assign o_row_cnt = row_cnt_q;
`endif

    // Two free entries leave room for the push already in flight when upstream sees ready drop.
    assign o_addr_ready = (state_q == ST_FILL || state_q == ST_HOLD) && free >= FW'(2);
    assign o_mem_ren    = pop;
    assign o_mem_addr   = pop ? head : '0;
    assign o_row_data   = row_q;
    assign o_row_len    = len_q;
    assign o_row_valid  = row_valid_q;
    assign o_all_done   = all_done_q;
    assign o_cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_im2col_row_packer.sv
// tb_im2col_row_packer: directed scenarios with an address-order scoreboard checking packed rows.
module tb_im2col_row_packer;
    import im2col_row_packer_pkg::*;
    localparam int DW = 8;
    localparam int RM = 32;

    logic                     clk = 1'b0, rstn = 1'b0, enable = 1'b0;
    logic [KERNEL_SIZE-1:0]   kernel_size = '0;
    logic [CHANNELS_SIZE-1:0] channels = '0;
    logic [ADDR_SIZE-1:0]     i_addr = '0, o_mem_addr;
    logic                     i_addr_valid = 1'b0, i_done = 1'b0, i_row_ready = 1'b0;
    logic                     o_addr_ready, o_mem_ren, o_row_valid, o_all_done, o_cfg_err;
    logic [DW-1:0]            mem_rdata = '0;
    logic [RM*DW-1:0]         o_row_data;
    logic [5:0]               o_row_len;

    int n_chk = 0, n_fail = 0;
    logic [ADDR_SIZE-1:0] src_q[$];
    logic [DW-1:0]        exp_q[$];

    im2col_row_packer #(.DATA_W(DW), .ROW_MAX(RM), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .kernel_size  (kernel_size),
        .channels     (channels),
        .i_addr       (i_addr),
        .i_addr_valid (i_addr_valid),
        .i_done       (i_done),
        .o_addr_ready (o_addr_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_ren    (o_mem_ren),
        .i_mem_rdata  (mem_rdata),
        .o_row_data   (o_row_data),
        .o_row_len    (o_row_len),
        .o_row_valid  (o_row_valid),
        .i_row_ready  (i_row_ready),
        .o_all_done   (o_all_done),
        .o_cfg_err    (o_cfg_err)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, data is the low address byte.
    always @(posedge clk) if (o_mem_ren) mem_rdata <= o_mem_addr[7:0];

    task automatic chk(input string tag, input logic [RM*DW-1:0] obs, input logic [RM*DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RM*DW-1:0] take(input int n);
        logic [RM*DW-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            if (exp_q.size() > 0) r[i*DW +: DW] = exp_q.pop_front();
        return r;
    endfunction

    task automatic drive_one();
        if (src_q.size() > 0 && o_addr_ready) begin
            i_addr       = src_q.pop_front();
            i_addr_valid = 1'b1;
            exp_q.push_back(i_addr[7:0]);
        end else begin
            i_addr_valid = 1'b0;
        end
    endtask

    task automatic gen_std();
        for (int oy = 0; oy < 4; oy++)
            for (int ox = 0; ox < 4; ox++)
                for (int ky = 0; ky < 2; ky++)
                    for (int kx = 0; kx < 2; kx++)
                        for (int c = 0; c < 4; c++)
                            src_q.push_back(16'(((oy*2 + ky)*8 + ox*2 + kx)*4 + c));
    endtask

    task automatic go_idle();
        enable = 1'b0; i_done = 1'b0; i_addr_valid = 1'b0; i_row_ready = 1'b0;
        src_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int k, input int c, input int exp_rows, input bit hold);
        int rows = 0;
        int len = k * k * c;
        logic [RM*DW-1:0] er;
        kernel_size = KERNEL_SIZE'(k); channels = CHANNELS_SIZE'(c);
        i_done = 1'b0; i_row_ready = 1'b1; enable = 1'b1;
        fork
            begin
                for (int cyc = 0; cyc < 4000 && src_q.size() > 0; cyc++) begin
                    @(negedge clk);
                    drive_one();
                end
                @(negedge clk);
                i_addr_valid = 1'b0;
                i_done       = 1'b1;
            end
            begin
                for (int cyc = 0; cyc < 6000 && !o_all_done; cyc++) begin
                    @(negedge clk);
                    if (o_row_valid) begin
                        er = take(len);
                        chk("row_len", o_row_len, (RM*DW)'(len));
                        chk($sformatf("row%0d", rows), o_row_data, er);
                        if (hold && rows == 0) begin
                            i_row_ready = 1'b0;
                            repeat (20) begin
                                @(negedge clk);
                                chk("row_stable", o_row_data, er);
                            end
                            chk("addr_ready_full", o_addr_ready, 0);
                            i_row_ready = 1'b1;
                        end
                        rows++;
                    end
                end
            end
        join
        chk("row_count", rows, exp_rows);
        chk("all_done", o_all_done, 1);
    endtask

    initial begin
        int ren_cnt;
        repeat (3) @(negedge clk);
        chk("rst_row_valid", o_row_valid, 0);
        chk("rst_addr_ready", o_addr_ready, 0);
        chk("rst_row_data", o_row_data, 0);
        chk("rst_flags", {o_all_done, o_cfg_err, o_mem_ren, o_row_len}, 0);
        rstn = 1'b1;
        @(negedge clk);

        gen_std();
        run(2, 4, 16, 1'b0);
        go_idle();

        gen_std();
        run(2, 4, 16, 1'b1);
        go_idle();

        kernel_size = 4'd6; channels = 8'd1; enable = 1'b1; ren_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_mem_ren || o_row_valid) ren_cnt++;
            i_addr_valid = 1'b1;
            i_addr       = 16'h0011;
        end
        chk("cfg_err", o_cfg_err, 1);
        chk("cfg_no_activity", ren_cnt, 0);
        chk("cfg_len", o_row_len, 36);
        go_idle();
        chk("cfg_err_clear", o_cfg_err, 0);

        for (int i = 0; i < 6; i++) src_q.push_back(16'(8'hA0 + i));
        run(2, 1, 2, 1'b0);
        go_idle();

        gen_std();
        kernel_size = 4'd2; channels = 8'd4; enable = 1'b1; ren_cnt = 0;
        for (int cyc = 0; cyc < 200 && ren_cnt < 6; cyc++) begin
            @(negedge clk);
            if (o_mem_ren) ren_cnt++;
            if (ren_cnt < 6) drive_one();
        end
        enable = 1'b0; i_addr_valid = 1'b0;
        @(negedge clk);
        chk("abort_row_data", o_row_data, 0);
        chk("abort_flags", {o_row_valid, o_mem_ren, o_addr_ready, o_row_len}, 0);
        go_idle();
        gen_std();
        run(2, 4, 16, 1'b0);
        go_idle();

        for (int i = 0; i < 4; i++) src_q.push_back(16'(8'h51 + i));
        kernel_size = 4'd2; channels = 8'd1; enable = 1'b1; i_row_ready = 1'b0;
        for (int cyc = 0; cyc < 100 && !o_row_valid; cyc++) begin
            @(negedge clk);
            drive_one();
        end
        i_addr_valid = 1'b0;
        chk("hold_before_reset", o_row_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_row_valid", o_row_valid, 0);
        chk("async_row_data", o_row_data, 0);
        chk("async_flags", {o_row_len, o_addr_ready, o_all_done, o_cfg_err, o_mem_ren}, 0);
        enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
